fpmul_arbiter: RTL and testbench
================================

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: max cycles waited for mul_done_i after mul_start_o.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid_i  input  1  requester 0 has an operation pending.
REQ-005 req0_ready_o  output  1  requester 0 operation accepted this cycle when high with req0_valid_i.
REQ-006 req0_a_i, req0_b_i  input  32 each  requester 0 IEEE-754 single operands.
REQ-007 req1_valid_i, req1_ready_o, req1_a_i, req1_b_i  same as REQ-004..006 for requester 1.
REQ-008 rsp_valid_o  output  1  response available.
REQ-009 rsp_ready_i  input  1  response consumer accepts when high with rsp_valid_o.
REQ-010 rsp_id_o  output  1  requester index owning the response.
REQ-011 rsp_product_o  output  32  product returned by the multiplier.
REQ-012 rsp_flags_o  output  5  {timeout, underflow, overflow, infinit, nan}, bit 0 = nan.
REQ-013 mul_start_o  output  1  one-cycle start pulse to multiplier32FP start_i.
REQ-014 mul_a_o, mul_b_o  output  32 each  operands to multiplier32FP a_i/b_i.
REQ-015 mul_product_i  input  32  multiplier32FP product_o.
REQ-016 mul_done_i, mul_nan_i, mul_infinit_i, mul_overflow_i, mul_underflow_i  input  1 each  multiplier32FP status outputs.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-018 IDLE: grant = requester with priority if valid, else the other if valid; reqN_ready_o = (state==IDLE) && grant==N && reqN_valid_i-independent of other ready (combinational).
REQ-019 Priority: after reset req0 has priority; after each RESP handshake, priority moves to the requester not just served (round-robin).
REQ-020 On acceptance: latch operands and id into internal registers, IDLE -> ISSUE next cycle.
REQ-021 ISSUE: mul_start_o = 1 for exactly one cycle, mul_a_o/mul_b_o = latched operands; -> WAIT.
REQ-022 mul_a_o/mul_b_o hold latched operands from ISSUE until leaving WAIT; mul_start_o = 0 in all other states.
REQ-023 WAIT: 6-bit-or-wider counter cleared on entry, increments each cycle; mul_done_i high -> capture product and four flags, timeout = 0, -> RESP.
REQ-024 WAIT: counter reaches TIMEOUT-1 without mul_done_i -> rsp_product_o = 0, flags = 5'b10000, -> RESP; done in same cycle as expiry wins (normal capture).
REQ-025 RESP: rsp_valid_o = 1, rsp_id_o/product/flags stable until rsp_ready_i sampled high; then -> IDLE, priority update.
REQ-026 rsp_valid_o asserted the cycle after mul_done_i is sampled; minimum accept-to-rsp_valid latency = multiplier latency + 2 cycles.
REQ-027 Requests arriving outside IDLE are not accepted; valid/operands must be held by requester until ready.
REQ-028 mul_done_i outside WAIT is ignored.
REQ-029 No internal arithmetic on operands or product; values pass unchanged.

Reset
REQ-030 rst_n low asynchronously forces state IDLE, priority = req0, counter = 0, all outputs and latched registers = 0.
REQ-031 Reset mid-WAIT abandons the operation; no response produced; first post-reset request handled normally.
REQ-032 First acceptance possible on the first rising edge with rst_n high.

Verification
REQ-033 req0 a=0x40200000 (2.5), b=0x40800000 (4.0) -> one mul_start_o pulse, rsp id=0, product 0x41200000, flags 0.
REQ-034 req0 and req1 valid same cycle after reset -> req0 served first, then req1; both held valid -> grants alternate 0,1,0,1.
REQ-035 req1 a=0x3F800000, b=0x7F800001 (NaN) -> rsp id=1, flags bit 0 set; a=0x7F7FFFFF twice -> overflow bit set.
REQ-036 Multiplier model never asserts done -> after TIMEOUT cycles rsp flags=5'b10000, product 0, next request proceeds.
REQ-037 rsp_ready_i held low 10 cycles -> rsp outputs stable, no new acceptance, req ready low throughout.
REQ-038 rst_n pulsed low during WAIT -> outputs 0 immediately, no stale response, next request yields correct product.

Source files
------------

// File: rtl/fpmul_arbiter.sv
// Two-requester round-robin front end for a single-precision multiplier core.
// One operation is in flight at a time; a watchdog bounds the wait for the core's done pulse.
module fpmul_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req0_a_i,
    input  logic [31:0] req0_b_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [31:0] req1_a_i,
    input  logic [31:0] req1_b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [31:0] rsp_product_o,
    output logic [4:0]  rsp_flags_o,
    output logic        mul_start_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [31:0] mul_product_i,
    input  logic        mul_done_i,
    input  logic        mul_nan_i,
    input  logic        mul_infinit_i,
    input  logic        mul_overflow_i,
    input  logic        mul_underflow_i
);

    localparam int CW = ($clog2(TIMEOUT + 1) < 6) ? 6 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            prio_r;
    logic            id_r;
    logic [31:0]     op_a_r;
    logic [31:0]     op_b_r;
    logic [CW-1:0]   cnt_r;
    logic            mul_start_r;
    logic            rsp_valid_r;
    logic [31:0]     rsp_product_r;
    logic [4:0]      rsp_flags_r;

    logic            req_pri_s;
    logic            req_oth_s;
    logic            grant_s;
    logic            accept_s;
    logic            expire_s;
    logic            rsp_hs_s;

    // Grant selection: the priority holder wins, otherwise the other requester.
    always_comb begin
        req_pri_s = prio_r ? req1_valid_i : req0_valid_i;
        req_oth_s = prio_r ? req0_valid_i : req1_valid_i;
        if (req_pri_s) begin
            grant_s = prio_r;
        end else if (req_oth_s) begin
            grant_s = ~prio_r;
        end else begin
            grant_s = prio_r;
        end
    end

    assign accept_s     = (state_r == ST_IDLE) && (req_pri_s || req_oth_s);
    assign expire_s     = (cnt_r == CW'(TIMEOUT - 1));
    assign rsp_hs_s     = rsp_valid_r && rsp_ready_i;

    assign req0_ready_o = (state_r == ST_IDLE) && (grant_s == 1'b0) && req0_valid_i;
    assign req1_ready_o = (state_r == ST_IDLE) && (grant_s == 1'b1) && req1_valid_i;

    assign mul_start_o   = mul_start_r;
    assign mul_a_o       = op_a_r;
    assign mul_b_o       = op_b_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_id_o      = id_r;
    assign rsp_product_o = rsp_product_r;
    assign rsp_flags_o   = rsp_flags_r;

    // Next-state logic for the single-operation sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done_i || expire_s) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch, start pulse, watchdog counter, response capture and priority rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r        <= 1'b0;
            id_r          <= 1'b0;
            op_a_r        <= 32'd0;
            op_b_r        <= 32'd0;
            cnt_r         <= {CW{1'b0}};
            mul_start_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_product_r <= 32'd0;
            rsp_flags_r   <= 5'd0;
        end else begin
            mul_start_r <= accept_s;
            if (accept_s) begin
                op_a_r <= grant_s ? req1_a_i : req0_a_i;
                op_b_r <= grant_s ? req1_b_i : req0_b_i;
                id_r   <= grant_s;
            end
            if (state_r == ST_ISSUE) begin
                cnt_r <= {CW{1'b0}};
            end else if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r + CW'(1);
            end
            // A done arriving on the expiry cycle takes precedence over the timeout.
            if ((state_r == ST_WAIT) && mul_done_i) begin
                rsp_valid_r   <= 1'b1;
                rsp_product_r <= mul_product_i;
                rsp_flags_r   <= {1'b0, mul_underflow_i, mul_overflow_i, mul_infinit_i, mul_nan_i};
            end else if ((state_r == ST_WAIT) && expire_s) begin
                rsp_valid_r   <= 1'b1;
                rsp_product_r <= 32'd0;
                rsp_flags_r   <= 5'b10000;
            end else if (rsp_hs_s) begin
                rsp_valid_r <= 1'b0;
                prio_r      <= ~id_r;
            end
        end
    end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter with a programmable-latency multiplier stand-in.
module tb_fpmul_arbiter;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        req0_valid_i, req0_ready_o;
    logic [31:0] req0_a_i, req0_b_i;
    logic        req1_valid_i, req1_ready_o;
    logic [31:0] req1_a_i, req1_b_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_id_o;
    logic [31:0] rsp_product_o;
    logic [4:0]  rsp_flags_o;
    logic        mul_start_o;
    logic [31:0] mul_a_o, mul_b_o;
    logic [31:0] mul_product_i;
    logic        mul_done_i, mul_nan_i, mul_infinit_i, mul_overflow_i, mul_underflow_i;

    int          n_checks;
    int          n_errors;

    int          mdl_lat;
    bit          mdl_en;
    logic        spur_done;
    logic        mdl_busy;
    int          mdl_cnt;
    logic        mdl_done_r;
    logic [31:0] seen_a, seen_b;
    int          mdl_starts;

    assign mul_done_i = mdl_done_r | spur_done;

    fpmul_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_product_o(rsp_product_o), .rsp_flags_o(rsp_flags_o),
        .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_product_i(mul_product_i), .mul_done_i(mul_done_i),
        .mul_nan_i(mul_nan_i), .mul_infinit_i(mul_infinit_i),
        .mul_overflow_i(mul_overflow_i), .mul_underflow_i(mul_underflow_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: done rises mdl_lat cycles after start is sampled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_busy   <= 1'b0;
            mdl_cnt    <= 0;
            mdl_done_r <= 1'b0;
            mdl_starts <= 0;
            seen_a     <= 32'd0;
            seen_b     <= 32'd0;
        end else begin
            mdl_done_r <= 1'b0;
            if (mdl_busy) begin
                if (mdl_cnt <= 1) begin
                    mdl_done_r <= mdl_en;
                    mdl_busy   <= 1'b0;
                end else begin
                    mdl_cnt <= mdl_cnt - 1;
                end
            end
            if (mul_start_o) begin
                mdl_busy   <= 1'b1;
                mdl_cnt    <= mdl_lat;
                seen_a     <= mul_a_o;
                seen_b     <= mul_b_o;
                mdl_starts <= mdl_starts + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_mul(input logic [31:0] prod, input logic [3:0] fl);
        mul_product_i   = prod;
        mul_underflow_i = fl[3];
        mul_overflow_i  = fl[2];
        mul_infinit_i   = fl[1];
        mul_nan_i       = fl[0];
    endtask

    task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 1'b0;
        if (id) begin
            req1_valid_i = 1'b1; req1_a_i = a; req1_b_i = b;
        end else begin
            req0_valid_i = 1'b1; req0_a_i = a; req0_b_i = b;
        end
        for (int i = 0; i < 100 && !ok; i++) begin
            #1;
            if ((id ? req1_ready_o : req0_ready_o) === 1'b1) begin
                ok = 1'b1;
                @(posedge clk);
            end
            @(negedge clk);
        end
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        if (!ok) check("accept_wait", 32'd0, 32'd1);
    endtask

    task automatic ack_rsp(input string tag);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0;
        check({tag, "_drop"}, 32'(rsp_valid_o), 32'd0);
    endtask

    task automatic get_rsp(input string tag, input logic id, input logic [31:0] prod,
                           input logic [4:0] flags, input int lat, input bit ack);
        int n;
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
        check({tag, "_id"}, 32'(rsp_id_o), 32'(id));
        check({tag, "_prod"}, rsp_product_o, prod);
        check({tag, "_flags"}, 32'(rsp_flags_o), 32'(flags));
        if (lat >= 0) check({tag, "_lat"}, 32'(n), 32'(lat));
        if (ack) ack_rsp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bit stale;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; rsp_ready_i = 1'b0; spur_done = 1'b0;
        req0_valid_i = 1'b0; req0_a_i = 32'd0; req0_b_i = 32'd0;
        req1_valid_i = 1'b0; req1_a_i = 32'd0; req1_b_i = 32'd0;
        mdl_lat = 3; mdl_en = 1'b1;
        set_mul(32'd0, 4'd0);

        repeat (2) @(negedge clk);
        check("rst_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_start", 32'(mul_start_o), 32'd0);
        check("rst_a", mul_a_o, 32'd0);
        check("rst_b", mul_b_o, 32'd0);
        check("rst_prod", rsp_product_o, 32'd0);
        check("rst_flags", 32'(rsp_flags_o), 32'd0);
        rst_n = 1'b1;

        // 2.5 * 4.0 = 10.0
        set_mul(32'h41200000, 4'd0);
        s0 = mdl_starts;
        send(1'b0, 32'h40200000, 32'h40800000);
        get_rsp("basic", 1'b0, 32'h41200000, 5'd0, 5, 1'b1);
        check("basic_a", seen_a, 32'h40200000);
        check("basic_b", seen_b, 32'h40800000);
        check("basic_starts", 32'(mdl_starts - s0), 32'd1);

        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        check("spur_idle", 32'(rsp_valid_o), 32'd0);

        // Both requesters held valid from reset: grants alternate 0,1,0,1.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_mul(32'h3F800000, 4'd0);
        req0_valid_i = 1'b1; req0_a_i = 32'h11111111; req0_b_i = 32'h22222222;
        req1_valid_i = 1'b1; req1_a_i = 32'h33333333; req1_b_i = 32'h44444444;
        #1;
        check("both_rdy0", 32'(req0_ready_o), 32'd1);
        check("both_rdy1", 32'(req1_ready_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                get_rsp("alt", 1'b1, 32'h3F800000, 5'd0, -1, 1'b0);
                req0_valid_i = 1'b0;
                req1_valid_i = 1'b0;
                ack_rsp("alt");
            end else begin
                get_rsp("alt", (i % 2) == 1, 32'h3F800000, 5'd0, -1, 1'b1);
            end
            check("alt_a", seen_a, (i % 2) == 1 ? 32'h33333333 : 32'h11111111);
        end

        // Flag pass-through: NaN, overflow+infinity, underflow.
        set_mul(32'h7FC00000, 4'b0001);
        send(1'b1, 32'h3F800000, 32'h7F800001);
        get_rsp("nan", 1'b1, 32'h7FC00000, 5'b00001, 5, 1'b1);
        set_mul(32'h7F800000, 4'b0110);
        send(1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF);
        get_rsp("ovf", 1'b1, 32'h7F800000, 5'b00110, 5, 1'b1);
        set_mul(32'h00000000, 4'b1000);
        send(1'b0, 32'h00800000, 32'h00800000);
        get_rsp("unf", 1'b0, 32'h00000000, 5'b01000, 5, 1'b1);

        // Watchdog: no done, done on the expiry cycle, done one cycle late.
        mdl_en = 1'b0;
        set_mul(32'hDEADBEEF, 4'b1111);
        send(1'b0, 32'h40000000, 32'h40000000);
        get_rsp("tmo", 1'b0, 32'd0, 5'b10000, TO + 1, 1'b1);
        mdl_en = 1'b1;
        mdl_lat = TO - 1;
        set_mul(32'h12345678, 4'd0);
        send(1'b0, 32'h3F000000, 32'h3F000000);
        get_rsp("edge", 1'b0, 32'h12345678, 5'd0, TO + 1, 1'b1);
        mdl_lat = TO;
        send(1'b1, 32'h3F000000, 32'h3F000000);
        get_rsp("late", 1'b1, 32'd0, 5'b10000, TO + 1, 1'b1);
        mdl_lat = 3;
        set_mul(32'h41200000, 4'd0);
        send(1'b0, 32'h40200000, 32'h40800000);
        get_rsp("after_tmo", 1'b0, 32'h41200000, 5'd0, 5, 1'b1);

        // Consumer stalls for 10 cycles while requester 0 waits.
        set_mul(32'h40400000, 4'd0);
        send(1'b1, 32'h3FC00000, 32'h40000000);
        get_rsp("stall", 1'b1, 32'h40400000, 5'd0, 5, 1'b0);
        req0_valid_i = 1'b1; req0_a_i = 32'h40A00000; req0_b_i = 32'h40A00000;
        s0 = mdl_starts;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("stall_valid", 32'(rsp_valid_o), 32'd1);
            check("stall_id", 32'(rsp_id_o), 32'd1);
            check("stall_prod", rsp_product_o, 32'h40400000);
            check("stall_rdy0", 32'(req0_ready_o), 32'd0);
        end
        req0_valid_i = 1'b0;
        check("stall_starts", 32'(mdl_starts - s0), 32'd0);
        ack_rsp("stall");

        // Reset while waiting on the multiplier.
        mdl_en = 1'b0;
        send(1'b0, 32'h40E00000, 32'h40E00000);
        repeat (3) @(negedge clk);
        check("mid_a_before", mul_a_o, 32'h40E00000);
        rst_n = 1'b0;
        #1;
        check("mid_rst_a", mul_a_o, 32'd0);
        check("mid_rst_b", mul_b_o, 32'd0);
        check("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        check("mid_rst_start", 32'(mul_start_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_en = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < TO + 4; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0) stale = 1'b1;
        end
        check("mid_no_stale", 32'(stale), 32'd0);
        set_mul(32'h41200000, 4'd0);
        send(1'b1, 32'h40200000, 32'h40800000);
        get_rsp("post_rst", 1'b1, 32'h41200000, 5'd0, 5, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
